onehot_code_decoder: RTL and testbench
======================================

Name: onehot_code_decoder

Overview:
- Takes the 3-bit priority code plus valid flag produced by the switch encoder and expands it back to an 8-bit one-hot LED pattern.
- Buffers incoming codes in a small FIFO.
- Shows each decoded pattern for a fixed number of clock cycles, so short switch events are visible on ledr/seg.
- Sits between the encoder output and the LED/segment drivers in top.

Parameters:
- HOLD_CYCLES, 4, cycles each decoded pattern stays on out_onehot (legal range 1..65535).
- FIFO_DEPTH, 4, number of buffered {flag,code} entries (power of 2, at least 2).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  the input entry is valid this cycle.
- in_ready  output  1  FIFO can accept an entry; equals !full and does not depend on a pop in the same cycle.
- in_code  input  3  encoded switch index, 0..7.
- in_flag  input  1  1 = a switch is active; 0 = no switch (blank slot).
- out_onehot  output  8  decoded pattern, registered.
- out_valid  output  1  out_onehot is currently being displayed.
- busy  output  1  FSM is in SHOW or the FIFO is non-empty.
- overflow  output  1  sticky; set when in_valid is high while in_ready is low.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO empty; in_ready=1.
  - out_onehot=8'h00, out_valid=0, busy=0, overflow=0.
  - FSM in IDLE, hold counter = 0.
  - Reset mid-display or with a full FIFO discards all entries.
- Push: on an edge where in_valid && in_ready, write {in_flag,in_code} at the write pointer. Pointers wrap modulo FIFO_DEPTH. A count register (width clog2(FIFO_DEPTH)+1) tracks occupancy.
- Full/empty:
  - full = (count == FIFO_DEPTH); empty = (count == 0).
  - Push when full is ignored and sets overflow. Overflow stays set until reset.
- Simultaneous push and pop (not full): both happen and count is unchanged.
- Decode: pattern = in_flag ? (8'b1 << in_code) : 8'h00.
  - A blank entry is still displayed (out_valid=1, out_onehot=0) for its full hold time.
- FSM states:
  - IDLE:
    - out_valid=0, out_onehot=0.
    - If !empty: pop the head, load out_onehot with the decoded head, set out_valid=1, hold_cnt=HOLD_CYCLES-1, go to SHOW.
  - SHOW:
    - If hold_cnt != 0: decrement and keep the output.
    - If hold_cnt == 0 and !empty: pop and load the next entry back-to-back (no gap cycle), reload hold_cnt, stay in SHOW.
    - If hold_cnt == 0 and empty: go to IDLE; out_valid=0, out_onehot=0 after that edge.
- Latency: an entry pushed at edge N into an empty FIFO with the FSM in IDLE appears on out_onehot after edge N+1. Each entry is visible for exactly HOLD_CYCLES cycles.
- Ordering is strict FIFO; no entries are merged or dropped except on overflow.
- HOLD_CYCLES=1: a new entry every cycle while the FIFO is non-empty.
- hold_cnt width is 16 bits.
- busy = (state == SHOW) || !empty.

Decomposition:
- Shared package onehot_pkg:
  - CODE_W=3, ONEHOT_W=8.
  - Entry type {flag, code[2:0]}.
  - FSM state enum {IDLE, SHOW}.
  - Decode function code_to_onehot(flag, code).
- One sub-module: code_fifo, a synchronous FIFO parameterised by depth and width, exposing full, empty, count, push and pop.
- The top level holds the FSM, hold counter, output registers and overflow flag.

Test Plan:
- Reset, then push {1,3'd5} at edge 1 -> out_onehot=8'h20 and out_valid=1 from after edge 2 through edge 5; 8'h00 and out_valid=0 after edge 6; busy=0.
- Push {1,3'd0}, {1,3'd7}, {0,3'd2} on consecutive cycles -> out_onehot shows 8'h01 for 4 cycles, 8'h80 for 4, then 8'h00 with out_valid=1 for 4, with no gap cycles; then IDLE.
- Push 6 entries back-to-back with HOLD_CYCLES=4 -> entries 1..5 accepted (one popped first, 4 buffered), in_ready=0 on the 6th cycle, overflow=1 and stays 1; the 6th entry is never displayed.
- Sweep codes 0..7 with flag=1 and HOLD_CYCLES=1 -> out_onehot 8'h01, 02, 04, ..., 80 on consecutive cycles.
- Assert rst low mid-SHOW with 3 entries queued -> outputs go to 0 immediately (asynchronously); after release, out_valid stays 0 and nothing is displayed without a new push.
- Push and pop in the same cycle with count=2 -> count stays 2, in_ready stays 1, display order preserved.

Source files
------------

// File: rtl/onehot_code_decoder_pkg.sv
// Shared definitions for the one-hot code decoder slice.
//   CODE_W / ONEHOT_W : width of the encoded switch index and of the LED pattern
//   entry_t           : one buffered {flag, code} slot
//   state_t           : display FSM states
//   code_to_onehot    : expands {flag, code} into the LED pattern (all zero when flag=0)
package onehot_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef struct packed {
        logic              flag;
        logic [CODE_W-1:0] code;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    function automatic logic [ONEHOT_W-1:0] code_to_onehot(
        input logic              flag,
        input logic [CODE_W-1:0] code
    );
        logic [ONEHOT_W-1:0] result;
        result = '0;
        for (int i = 0; i < ONEHOT_W; i++) begin
            result[i] = flag && (code == CODE_W'(i));
        end
        return result;
    endfunction

endpackage

// File: rtl/onehot_code_decoder_if.sv
// Handshake/display bundle between the switch encoder side and the decoder.
//   in_valid/in_code/in_flag : entry offered by the encoder (master drives)
//   in_ready                 : decoder can accept an entry (slave drives)
//   out_onehot/out_valid     : pattern currently on display (slave drives)
//   busy/overflow            : status (slave drives)
interface onehot_code_decoder_if;
    import onehot_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [CODE_W-1:0]   in_code;
    logic                in_flag;
    logic [ONEHOT_W-1:0] out_onehot;
    logic                out_valid;
    logic                busy;
    logic                overflow;

    modport master (
        output in_valid, in_code, in_flag,
        input  in_ready, out_onehot, out_valid, busy, overflow
    );

    modport slave (
        input  in_valid, in_code, in_flag,
        output in_ready, out_onehot, out_valid, busy, overflow
    );

endinterface

// File: rtl/onehot_code_decoder_code_fifo.sv
// Small synchronous FIFO for buffered decoder entries.
//   clk, rst        : clock, asynchronous active-low reset (empties the FIFO)
//   push / wr_data  : write an entry when not full (push while full is ignored)
//   pop  / rd_data  : rd_data always shows the head; pop advances it when not empty
//   full/empty/count: occupancy status, count is 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module code_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [COUNT_W-1:0] count_reg;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count_reg == COUNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Head is read combinationally so the consumer can pop and load the
    // entry on the same edge, which keeps back-to-back display gap-free.
    assign rd_data = mem[rd_ptr_reg];

    // Storage has no reset: clearing the pointers and count is what
    // discards the contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + COUNT_W'(1);
                2'b01:   count_reg <= count_reg - COUNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/onehot_code_decoder.sv
// Expands buffered {flag, code} entries into an 8-bit one-hot LED pattern and
// keeps each pattern on display for HOLD_CYCLES clocks.
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   bus      : slave side of onehot_code_decoder_if
//              (in_valid/in_ready/in_code/in_flag in, out_onehot/out_valid/
//               busy/overflow out)
// Parameters: HOLD_CYCLES (1..65535) display time per entry,
//             FIFO_DEPTH (power of two, >= 2) buffered entries.
module onehot_code_decoder
    import onehot_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    onehot_code_decoder_if.slave bus
);

    localparam int          COUNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] HOLD_RELOAD = 16'(HOLD_CYCLES - 1);

    entry_t                wr_entry;
    entry_t                head_entry;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [COUNT_W-1:0]    fifo_count;
    logic                  pop;

    state_t                state_reg;
    logic [15:0]           hold_cnt_reg;
    logic [ONEHOT_W-1:0]   out_onehot_reg;
    logic                  out_valid_reg;
    logic                  overflow_reg;

    assign wr_entry.flag = bus.in_flag;
    assign wr_entry.code = bus.in_code;

    code_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.in_valid),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // The head is consumed whenever the display slot is free: either nothing
    // is shown, or the current pattern is in its last hold cycle.
    assign pop = !fifo_empty && ((state_reg == IDLE) || (hold_cnt_reg == 16'd0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            hold_cnt_reg   <= 16'd0;
            out_onehot_reg <= '0;
            out_valid_reg  <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            if (bus.in_valid && fifo_full) begin
                overflow_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        out_onehot_reg <= code_to_onehot(head_entry.flag, head_entry.code);
                        out_valid_reg  <= 1'b1;
                        hold_cnt_reg   <= HOLD_RELOAD;
                        state_reg      <= SHOW;
                    end
                end
                SHOW: begin
                    if (hold_cnt_reg != 16'd0) begin
                        hold_cnt_reg <= hold_cnt_reg - 16'd1;
                    end else if (pop) begin
                        out_onehot_reg <= code_to_onehot(head_entry.flag, head_entry.code);
                        out_valid_reg  <= 1'b1;
                        hold_cnt_reg   <= HOLD_RELOAD;
                    end else begin
                        out_onehot_reg <= '0;
                        out_valid_reg  <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
            endcase
        end
    end

    // in_ready looks only at occupancy, never at a same-cycle pop.
    assign bus.in_ready   = !fifo_full;
    assign bus.out_onehot = out_onehot_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.overflow   = overflow_reg;
    assign bus.busy       = (state_reg == SHOW) || (fifo_count != '0);

endmodule

// File: tb/tb_onehot_code_decoder.sv
// Drives two decoders (HOLD_CYCLES=4 and HOLD_CYCLES=1) with identical
// stimulus and compares every cycle against a schedule-based model: each
// accepted entry gets a display start edge = max(push edge + 1, previous
// start + HOLD), and is visible for HOLD cycles after that edge.
module tb_onehot_code_decoder;

    localparam int DEPTH = 4;
    localparam int MAXE  = 1024;

    logic clk;
    logic rst;

    onehot_code_decoder_if bus0();
    onehot_code_decoder_if bus1();

    onehot_code_decoder #(.HOLD_CYCLES(4), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    onehot_code_decoder #(.HOLD_CYCLES(1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec       = 0;
    int n_checks    = 0;
    int miscompares = 0;
    int edge_n      = 0;

    // Reference model state per instance.
    int          hold_of [2] = '{4, 1};
    int          m_n     [2];
    int          m_p     [2][MAXE];
    int          m_q     [2][MAXE];
    logic [7:0]  m_pat   [2][MAXE];
    bit          m_ovf   [2];

    function automatic int occ_after(input int i, input int t);
        int c;
        c = 0;
        for (int k = 0; k < m_n[i]; k++) begin
            if (m_p[i][k] <= t && m_q[i][k] > t) c++;
        end
        return c;
    endfunction

    // {valid, pattern} shown after edge t
    function automatic logic [8:0] disp_after(input int i, input int t);
        for (int k = 0; k < m_n[i]; k++) begin
            if (m_q[i][k] <= t && t < m_q[i][k] + hold_of[i]) return {1'b1, m_pat[i][k]};
        end
        return 9'h000;
    endfunction

    task automatic model_edge(input int i, input int t, input logic v, input logic f,
                              input logic [2:0] c);
        bit rdy;
        int q;
        rdy = occ_after(i, t - 1) < DEPTH;
        if (v && rdy) begin
            q = t + 1;
            if (m_n[i] > 0 && m_q[i][m_n[i]-1] + hold_of[i] > q) q = m_q[i][m_n[i]-1] + hold_of[i];
            if (m_n[i] < MAXE) begin
                m_p[i][m_n[i]]   = t;
                m_q[i][m_n[i]]   = q;
                m_pat[i][m_n[i]] = f ? 8'(2 ** int'(c)) : 8'h00;
                m_n[i]++;
            end
        end else if (v) begin
            m_ovf[i] = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic [2:0] c);
        bus0.in_valid = v; bus0.in_flag = f; bus0.in_code = c;
        bus1.in_valid = v; bus1.in_flag = f; bus1.in_code = c;
    endtask

    task automatic step(input logic v, input logic f, input logic [2:0] c);
        logic [8:0] d0;
        logic [8:0] d1;
        drive(v, f, c);
        chk("in_ready_h4", 8'(bus0.in_ready), 8'(occ_after(0, edge_n) < DEPTH));
        chk("in_ready_h1", 8'(bus1.in_ready), 8'(occ_after(1, edge_n) < DEPTH));
        @(posedge clk);
        edge_n++;
        model_edge(0, edge_n, v, f, c);
        model_edge(1, edge_n, v, f, c);
        @(negedge clk);
        d0 = disp_after(0, edge_n);
        d1 = disp_after(1, edge_n);
        chk("onehot_h4",   bus0.out_onehot,      d0[7:0]);
        chk("valid_h4",    8'(bus0.out_valid),   8'(d0[8]));
        chk("busy_h4",     8'(bus0.busy),        8'(d0[8] || occ_after(0, edge_n) > 0));
        chk("overflow_h4", 8'(bus0.overflow),    8'(m_ovf[0]));
        chk("onehot_h1",   bus1.out_onehot,      d1[7:0]);
        chk("valid_h1",    8'(bus1.out_valid),   8'(d1[8]));
        chk("busy_h1",     8'(bus1.busy),        8'(d1[8] || occ_after(1, edge_n) > 0));
        chk("overflow_h1", 8'(bus1.overflow),    8'(m_ovf[1]));
        n_vec++;
        $display("vec %0d: v=%0b f=%0b c=%0d | h4 rdy=%0b val=%0b oh=%02h busy=%0b ovf=%0b | h1 rdy=%0b val=%0b oh=%02h busy=%0b ovf=%0b",
                 n_vec, v, f, c,
                 bus0.in_ready, bus0.out_valid, bus0.out_onehot, bus0.busy, bus0.overflow,
                 bus1.in_ready, bus1.out_valid, bus1.out_onehot, bus1.busy, bus1.overflow);
    endtask

    // Asserts reset mid-cycle and checks that outputs clear without a clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0);
        #1;
        chk("rst_onehot_h4",   bus0.out_onehot,     8'h00);
        chk("rst_valid_h4",    8'(bus0.out_valid),  8'h00);
        chk("rst_busy_h4",     8'(bus0.busy),       8'h00);
        chk("rst_overflow_h4", 8'(bus0.overflow),   8'h00);
        chk("rst_ready_h4",    8'(bus0.in_ready),   8'h01);
        chk("rst_onehot_h1",   bus1.out_onehot,     8'h00);
        chk("rst_valid_h1",    8'(bus1.out_valid),  8'h00);
        chk("rst_ready_h1",    8'(bus1.in_ready),   8'h01);
        for (int i = 0; i < 2; i++) begin
            m_n[i]   = 0;
            m_ovf[i] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        $display("reset applied");
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0);
        do_reset();

        // Single entry: code 5 shows 8'h20 one edge after the push.
        step(1'b1, 1'b1, 3'd5);
        step(1'b0, 1'b0, 3'd0);
        chk("first_show_h4", bus0.out_onehot, 8'h20);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 3'd0);

        // Three consecutive entries including a blank slot.
        step(1'b1, 1'b1, 3'd0);
        step(1'b1, 1'b1, 3'd7);
        step(1'b1, 1'b0, 3'd2);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 3'd0);

        // Six back-to-back pushes: the sixth overflows the HOLD=4 decoder.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 3'(i + 1));
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 3'd0);

        // Code sweep: HOLD=1 decoder walks the one-hot pattern every cycle.
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, 3'(k));
            if (k > 0) chk("sweep_h1", bus1.out_onehot, 8'(1 << (k - 1)));
        end
        step(1'b0, 1'b0, 3'd0);
        chk("sweep_last_h1", bus1.out_onehot, 8'h80);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 3'd0);

        // Reset mid-display with entries queued, then idle: nothing reappears.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'(i + 2));
        step(1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b0, 3'd0);
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 3'd0);

        // Randomized traffic with a reset part-way through.
        for (int n = 0; n < 300; n++) begin
            if (n == 150) do_reset();
            step(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
